anim_sprite: RTL and testbench
==============================

Name: anim_sprite

Overview:
- Generic animated-sprite overlay stage for the VGA pipeline.
- Replaces the per-object fixed drawers (ladder, shield, platform) with one parametrised block: size, frame count, scale, colour key and playback mode are all configurable.
- Sits between two vga_if stages and fetches pixels from an external image_rom with 1-cycle read latency.
- Advances the animation frame on vsync and overlays non-transparent sprite pixels onto the incoming rgb.

Parameters:
- SPRITE_W, 32: sprite width in ROM pixels.
- SPRITE_H, 32: sprite height in ROM pixels.
- FRAMES, 4: number of animation frames stored consecutively in the ROM.
- ADDR_BITS, 12: ROM address width; must satisfy 2^ADDR_BITS >= SPRITE_W*SPRITE_H*FRAMES.
- FRAME_TICKS, 8: number of video frames per animation step (>=1).
- SCALE_LOG2, 0: on-screen magnification of 2^SCALE_LOG2 (0..2).
- TRANSPARENT, 12'h000: colour key; ROM pixels equal to this value are not drawn.
- MODE, ANIM_LOOP: playback mode, type anim_mode_t (ANIM_LOOP, ANIM_PINGPONG, ANIM_ONESHOT).

Ports:
- clk  in  1  pixel clock (65 MHz).
- rst  in  1  asynchronous active-high reset.
- en  in  1  draw enable; 0 passes the pipeline through without overlay.
- start  in  1  one-cycle pulse: restart animation at frame 0.
- mirror  in  1  horizontal flip of the sprite.
- xpos  in  11  left edge of the sprite on screen.
- ypos  in  11  top edge of the sprite on screen.
- pixel_addr  out  ADDR_BITS  ROM address.
- rgb_pixel  in  12  ROM data, valid 1 cycle after pixel_addr.
- frame_idx  out  $clog2(FRAMES) (min 1)  current animation frame.
- done  out  1  one-shot playback finished.
- in  vga_if.in  -  upstream timing and rgb.
- out  vga_if.out  -  downstream timing and rgb.

Behaviour:
Reset:
- All out fields are 0; pixel_addr=0, frame_idx=0, done=0.
- State IDLE, tick counter 0, direction up.

Tick generation:
- vsync_q holds the registered in.vsync.
- tick = in.vsync & ~vsync_q (rising edge).
- The tick counter counts ticks 0..FRAME_TICKS-1.
- A step fires on the tick where the counter equals FRAME_TICKS-1; the counter then returns to 0.

State machine: IDLE, RUN, HOLD.
- IDLE: frame_idx=0; the sprite is still drawn (frame 0). start moves to RUN.
- RUN: each step advances frame_idx according to MODE.
  - LOOP: FRAMES-1 wraps to 0.
  - PINGPONG: the direction reverses at 0 and at FRAMES-1 (sequence 0,1,2,3,2,1,0,1...). With FRAMES=1, frame_idx stays 0.
  - ONESHOT: a step taken at FRAMES-1 enters HOLD with done=1 and frame_idx=FRAMES-1.
- HOLD: frame_idx is frozen; done stays 1 until start.
- start in any state: frame_idx=0, tick counter=0, direction up, done=0, state RUN.
- start and tick in the same cycle: start wins and the tick is discarded.
- frame_idx changes only on a vsync edge, so it is constant across every visible line.

Pixel pipeline (latency 2 cycles):
- Stage 1, combinational:
  - Bounds are computed in 12-bit arithmetic (no wrap).
  - inside = hcount in [xpos, xpos+(SPRITE_W<<SCALE_LOG2)) and vcount in [ypos, ypos+(SPRITE_H<<SCALE_LOG2)).
  - lx = (hcount-xpos)>>SCALE_LOG2; ly = (vcount-ypos)>>SCALE_LOG2.
  - If mirror=1, lx = SPRITE_W-1-lx.
  - addr = frame_idx*SPRITE_W*SPRITE_H + ly*SPRITE_W + lx when inside, otherwise 0.
- Stage 1 is registered into pixel_addr together with inside_d1 and en_d1.
- Stage 2 registers the output:
  - out timing fields = in fields delayed 2 cycles.
  - out.rgb = (inside_d2 & en_d2 & rgb_pixel != TRANSPARENT) ? rgb_pixel : in.rgb delayed 2 cycles.

Boundaries:
- A sprite partly beyond hcount 1343 or vcount 805 is clipped naturally; no wrap to the left or top edge.
- Changes to xpos, ypos or mirror take effect on the pixel at which they change, with no glitch beyond that pixel.
- Reset asserted mid-frame clears the pipeline within the same cycle (asynchronous reset).

Decomposition:
- Package anim_pkg holds:
  - anim_mode_t enum;
  - anim_state_t enum {IDLE, RUN, HOLD};
  - constants HOR_TOTAL=1344 and VER_TOTAL=806.
- Sub-module vga_delay (parameter DEPTH, vga_if in/out) is the timing/rgb delay line, reused by other overlay stages.

Test Plan:
1. Reset, then 32x32 sprite at (300,468) with en=1, FRAMES=1, rgb_pixel driven from the address -> pixel_addr=0 at hcount=300/vcount=468; out.rgb carries ROM data exactly 2 cycles later; pixel (299,468) passes in.rgb through.
2. LOOP, FRAMES=4, FRAME_TICKS=2, start -> frame_idx follows 0,0,1,1,2,2,3,3,0 at successive vsync rising edges.
3. PINGPONG, FRAMES=3, FRAME_TICKS=1 -> frame_idx follows 0,1,2,1,0,1; ONESHOT, FRAMES=3 -> 0,1,2, then done=1 and frame_idx stays 2 until start, which gives frame_idx=0 and done=0.
4. ROM returning TRANSPARENT (12'h000) inside the sprite area -> out.rgb equals in.rgb delayed; en=0 -> no overlay anywhere.
5. mirror=1, SCALE_LOG2=1 -> screen pixel (xpos,ypos) addresses lx=31; each ROM pixel covers 2x2 screen pixels; xpos=1330 clips after hcount 1343.
6. start asserted in the same cycle as a vsync edge, plus rst pulsed mid-line -> start wins (frame_idx=0); rst forces all outputs to 0 immediately.

Source files
------------

// File: rtl/anim_pkg.sv
`default_nettype none
// ============================================================================
// Module   : anim_pkg
// Brief    : shared types and video constants for animated sprite stages
// Revision : 1.0
// ============================================================================
package anim_pkg;

    typedef enum logic [1:0] {
        ANIM_LOOP     = 2'd0,
        ANIM_PINGPONG = 2'd1,
        ANIM_ONESHOT  = 2'd2
    } anim_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } anim_state_t;

    localparam int HOR_TOTAL = 1344;
    localparam int VER_TOTAL = 806;

    // Width of an index able to hold 0..n-1, never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_if
// Brief    : VGA timing plus rgb bundle passed between pipeline stages
// Revision : 1.0
// ============================================================================
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface
`default_nettype wire

// File: rtl/vga_delay.sv
`default_nettype none
// ============================================================================
// Module   : vga_delay
// Brief    : DEPTH-cycle register delay line for VGA timing and rgb
// Revision : 1.0
// ============================================================================
module vga_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    vga_if.in    in,
    vga_if.out   out
);
    localparam int W = 38;

    logic [W-1:0] w_in;
    logic [W-1:0] r_pipe [DEPTH];

    assign w_in = {in.vcount, in.vsync, in.vblnk, in.hcount, in.hsync, in.hblnk, in.rgb};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_in;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign {out.vcount, out.vsync, out.vblnk, out.hcount, out.hsync, out.hblnk, out.rgb} =
        r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/anim_sprite.sv
`default_nettype none
// ============================================================================
// Module   : anim_sprite
// Brief    : animated, scalable, colour-keyed sprite overlay stage
// Revision : 1.0
// ============================================================================
module anim_sprite
    import anim_pkg::*;
#(
    parameter int          SPRITE_W    = 32,
    parameter int          SPRITE_H    = 32,
    parameter int          FRAMES      = 4,
    parameter int          ADDR_BITS   = 12,
    parameter int          FRAME_TICKS = 8,
    parameter int          SCALE_LOG2  = 0,
    parameter logic [11:0] TRANSPARENT = 12'h000,
    parameter anim_mode_t  MODE        = ANIM_LOOP
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         start,
    input  logic                         mirror,
    input  logic [10:0]                  xpos,
    input  logic [10:0]                  ypos,
    output logic [ADDR_BITS-1:0]         pixel_addr,
    input  logic [11:0]                  rgb_pixel,
    output logic [idx_bits(FRAMES)-1:0]  frame_idx,
    output logic                         done,
    vga_if.in                            in,
    vga_if.out                           out
);
    localparam int             FW        = idx_bits(FRAMES);
    localparam int             CW        = idx_bits(FRAME_TICKS);
    localparam logic [FW-1:0]  LAST      = FW'(FRAMES - 1);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(FRAME_TICKS - 1);
    localparam int             FRAME_PIX = SPRITE_W * SPRITE_H;

    anim_state_t    r_state, w_state_nx;
    logic [FW-1:0]  r_frame, w_frame_nx;
    logic [CW-1:0]  r_cnt, w_cnt_nx;
    logic           r_dir_up, w_dir_nx;
    logic           r_done, w_done_nx;
    logic           r_vsync_q;
    logic           w_tick;
    logic           w_step;

    assign w_tick    = in.vsync & ~r_vsync_q;
    assign frame_idx = r_frame;
    assign done      = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_frame   <= '0;
            r_cnt     <= '0;
            r_dir_up  <= 1'b1;
            r_done    <= 1'b0;
            r_vsync_q <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_frame   <= w_frame_nx;
            r_cnt     <= w_cnt_nx;
            r_dir_up  <= w_dir_nx;
            r_done    <= w_done_nx;
            r_vsync_q <= in.vsync;
        end
    end

    // start overrides everything, including a tick in the same cycle.
    always_comb begin
        w_state_nx = r_state;
        w_frame_nx = r_frame;
        w_cnt_nx   = r_cnt;
        w_dir_nx   = r_dir_up;
        w_done_nx  = r_done;
        w_step     = 1'b0;
        if (start) begin
            w_state_nx = RUN;
            w_frame_nx = '0;
            w_cnt_nx   = '0;
            w_dir_nx   = 1'b1;
            w_done_nx  = 1'b0;
        end else if (w_tick) begin
            if (r_cnt == CNT_LAST) begin
                w_cnt_nx = '0;
                w_step   = 1'b1;
            end else begin
                w_cnt_nx = r_cnt + CW'(1);
            end
            if (w_step && (r_state == RUN)) begin
                case (MODE)
                    ANIM_LOOP: begin
                        w_frame_nx = (r_frame == LAST) ? '0 : r_frame + FW'(1);
                    end
                    ANIM_PINGPONG: begin
                        if (FRAMES > 1) begin
                            if (r_dir_up) begin
                                if (r_frame == LAST) begin
                                    w_dir_nx   = 1'b0;
                                    w_frame_nx = r_frame - FW'(1);
                                end else begin
                                    w_frame_nx = r_frame + FW'(1);
                                end
                            end else begin
                                if (r_frame == '0) begin
                                    w_dir_nx   = 1'b1;
                                    w_frame_nx = r_frame + FW'(1);
                                end else begin
                                    w_frame_nx = r_frame - FW'(1);
                                end
                            end
                        end
                    end
                    ANIM_ONESHOT: begin
                        if (r_frame == LAST) begin
                            w_state_nx = HOLD;
                            w_done_nx  = 1'b1;
                        end else begin
                            w_frame_nx = r_frame + FW'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Stage 1: sprite-local coordinates and ROM address (12-bit bounds, no wrap).
    logic [11:0]          w_hc, w_vc, w_x, w_y, w_xend, w_yend, w_dx, w_dy;
    logic                 w_inside;
    logic [ADDR_BITS-1:0] w_lx_raw, w_lx, w_ly, w_addr;

    assign w_hc     = {1'b0, in.hcount};
    assign w_vc     = {1'b0, in.vcount};
    assign w_x      = {1'b0, xpos};
    assign w_y      = {1'b0, ypos};
    assign w_xend   = w_x + 12'(SPRITE_W << SCALE_LOG2);
    assign w_yend   = w_y + 12'(SPRITE_H << SCALE_LOG2);
    assign w_inside = (w_hc >= w_x) && (w_hc < w_xend) && (w_vc >= w_y) && (w_vc < w_yend);
    assign w_dx     = w_hc - w_x;
    assign w_dy     = w_vc - w_y;
    assign w_lx_raw = ADDR_BITS'(w_dx >> SCALE_LOG2);
    assign w_ly     = ADDR_BITS'(w_dy >> SCALE_LOG2);
    assign w_lx     = mirror ? (ADDR_BITS'(SPRITE_W - 1) - w_lx_raw) : w_lx_raw;
    assign w_addr   = ADDR_BITS'(FRAME_PIX) * ADDR_BITS'(r_frame)
                    + ADDR_BITS'(SPRITE_W) * w_ly + w_lx;

    logic r_inside_d1, r_en_d1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_addr  <= '0;
            r_inside_d1 <= 1'b0;
            r_en_d1     <= 1'b0;
        end else begin
            pixel_addr  <= w_inside ? w_addr : '0;
            r_inside_d1 <= w_inside;
            r_en_d1     <= en;
        end
    end

    vga_if w_d1 ();

    vga_delay #(
        .DEPTH (1)
    ) u_delay (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .out (w_d1)
    );

    // Stage 2: the ROM word for pixel_addr is on rgb_pixel during this cycle.
    logic w_overlay;
    assign w_overlay = r_inside_d1 & r_en_d1 & (rgb_pixel != TRANSPARENT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out.vcount <= '0;
            out.vsync  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.hcount <= '0;
            out.hsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            out.vcount <= w_d1.vcount;
            out.vsync  <= w_d1.vsync;
            out.vblnk  <= w_d1.vblnk;
            out.hcount <= w_d1.hcount;
            out.hsync  <= w_d1.hsync;
            out.hblnk  <= w_d1.hblnk;
            out.rgb    <= w_overlay ? rgb_pixel : w_d1.rgb;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_anim_sprite.sv
`default_nettype none
// ============================================================================
// Module   : tb_anim_sprite
// Brief    : directed self-checking bench for anim_sprite
// Revision : 1.0
// ============================================================================
module tb_anim_sprite;
    import anim_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, start, mirror;
    logic [10:0] xpos, ypos;

    vga_if vin ();
    vga_if vout_a ();
    vga_if vout_s ();
    vga_if vout_l ();
    vga_if vout_p ();
    vga_if vout_o ();

    logic [11:0] addr_a, addr_s, addr_l, addr_p, addr_o;
    logic [11:0] rgbp_a, rgbp_s, rgbp_l, rgbp_p, rgbp_o;
    logic        fi_a, fi_s;
    logic [1:0]  fi_l, fi_p, fi_o;
    logic        done_a, done_s, done_l, done_p, done_o;

    // ROM model: address 5 holds the colour key, every other word is 0x800|addr.
    function automatic logic [11:0] rom_f(input logic [11:0] a);
        return (a == 12'd5) ? 12'h000 : (12'h800 | a);
    endfunction

    assign rgbp_a = rom_f(addr_a);
    assign rgbp_s = rom_f(addr_s);
    assign rgbp_l = rom_f(addr_l);
    assign rgbp_p = rom_f(addr_p);
    assign rgbp_o = rom_f(addr_o);

    logic [11:0] orgb_a, orgb_s;
    logic [10:0] ohc_a, ohc_s;
    assign orgb_a = vout_a.rgb;
    assign orgb_s = vout_s.rgb;
    assign ohc_a  = vout_a.hcount;
    assign ohc_s  = vout_s.hcount;

    anim_sprite #(.FRAMES(1)) u_a (
        .clk(clk), .rst(rst), .en(en), .start(start), .mirror(mirror), .xpos(xpos), .ypos(ypos),
        .pixel_addr(addr_a), .rgb_pixel(rgbp_a), .frame_idx(fi_a), .done(done_a),
        .in(vin), .out(vout_a));

    anim_sprite #(.FRAMES(1), .SCALE_LOG2(1)) u_s (
        .clk(clk), .rst(rst), .en(en), .start(start), .mirror(mirror), .xpos(xpos), .ypos(ypos),
        .pixel_addr(addr_s), .rgb_pixel(rgbp_s), .frame_idx(fi_s), .done(done_s),
        .in(vin), .out(vout_s));

    anim_sprite #(.FRAMES(4), .FRAME_TICKS(2), .MODE(ANIM_LOOP)) u_l (
        .clk(clk), .rst(rst), .en(en), .start(start), .mirror(mirror), .xpos(xpos), .ypos(ypos),
        .pixel_addr(addr_l), .rgb_pixel(rgbp_l), .frame_idx(fi_l), .done(done_l),
        .in(vin), .out(vout_l));

    anim_sprite #(.FRAMES(3), .FRAME_TICKS(1), .MODE(ANIM_PINGPONG)) u_p (
        .clk(clk), .rst(rst), .en(en), .start(start), .mirror(mirror), .xpos(xpos), .ypos(ypos),
        .pixel_addr(addr_p), .rgb_pixel(rgbp_p), .frame_idx(fi_p), .done(done_p),
        .in(vin), .out(vout_p));

    anim_sprite #(.FRAMES(3), .FRAME_TICKS(1), .MODE(ANIM_ONESHOT)) u_o (
        .clk(clk), .rst(rst), .en(en), .start(start), .mirror(mirror), .xpos(xpos), .ypos(ypos),
        .pixel_addr(addr_o), .rgb_pixel(rgbp_o), .frame_idx(fi_o), .done(done_o),
        .in(vin), .out(vout_o));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        sel;      // 0: unscaled sprite u_a, 1: 2x scaled sprite u_s
        logic [10:0] xpos;
        logic [10:0] ypos;
        logic        mir;
        logic        en;
        logic [10:0] hc;
        logic [10:0] vc;
        logic [11:0] rgb_in;
        logic [11:0] addr;
        logic [11:0] rgb_out;
    } vec_t;

    function automatic vec_t mk(input int sel, input int x, input int y, input int m, input int e,
                                input int hc, input int vc, input int ri, input int ad, input int ro);
        vec_t v;
        v.sel     = (sel != 0);
        v.xpos    = 11'(x);
        v.ypos    = 11'(y);
        v.mir     = (m != 0);
        v.en      = (e != 0);
        v.hc      = 11'(hc);
        v.vc      = 11'(vc);
        v.rgb_in  = 12'(ri);
        v.addr    = 12'(ad);
        v.rgb_out = 12'(ro);
        return v;
    endfunction

    function automatic int addr_of(input logic sel);
        return sel ? int'(addr_s) : int'(addr_a);
    endfunction
    function automatic int rgb_of(input logic sel);
        return sel ? int'(orgb_s) : int'(orgb_a);
    endfunction
    function automatic int hc_of(input logic sel);
        return sel ? int'(ohc_s) : int'(ohc_a);
    endfunction

    task automatic drive_vec(input vec_t v);
        xpos       = v.xpos;
        ypos       = v.ypos;
        mirror     = v.mir;
        en         = v.en;
        vin.hcount = v.hc;
        vin.vcount = v.vc;
        vin.rgb    = v.rgb_in;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vsync_pulse(input logic with_start);
        start     = with_start;
        vin.vsync = 1'b1;
        tick();
        start = 1'b0;
        tick();
        vin.vsync = 1'b0;
        tick();
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    localparam int NV = 23;
    vec_t vecs [NV];
    int   exp_l [8];
    int   exp_p [8];
    int   exp_o [8];
    int   exp_d [8];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(0, 300, 468, 0, 1, 300, 468, 'h123, 0,    'h800);
        vecs[1]  = mk(0, 300, 468, 0, 1, 301, 468, 'h124, 1,    'h801);
        vecs[2]  = mk(0, 300, 468, 0, 1, 299, 468, 'h0AB, 0,    'h0AB);
        vecs[3]  = mk(0, 300, 468, 0, 1, 331, 468, 'h125, 31,   'h81F);
        vecs[4]  = mk(0, 300, 468, 0, 1, 332, 468, 'h126, 0,    'h126);
        vecs[5]  = mk(0, 300, 468, 0, 1, 300, 469, 'h127, 32,   'h820);
        vecs[6]  = mk(0, 300, 468, 0, 1, 331, 499, 'h128, 1023, 'hBFF);
        vecs[7]  = mk(0, 300, 468, 0, 1, 300, 500, 'h129, 0,    'h129);
        vecs[8]  = mk(0, 300, 468, 0, 1, 300, 467, 'h12A, 0,    'h12A);
        vecs[9]  = mk(0, 300, 468, 0, 1, 305, 468, 'h3C3, 5,    'h3C3);
        vecs[10] = mk(0, 300, 468, 0, 0, 301, 468, 'h456, 1,    'h456);
        vecs[11] = mk(0, 300, 468, 1, 1, 300, 468, 'h457, 31,   'h81F);
        vecs[12] = mk(0, 300, 468, 1, 1, 331, 468, 'h458, 0,    'h800);
        vecs[13] = mk(1, 300, 468, 1, 1, 300, 468, 'h210, 31,   'h81F);
        vecs[14] = mk(1, 300, 468, 1, 1, 301, 468, 'h211, 31,   'h81F);
        vecs[15] = mk(1, 300, 468, 1, 1, 302, 468, 'h212, 30,   'h81E);
        vecs[16] = mk(1, 300, 468, 1, 1, 301, 469, 'h213, 31,   'h81F);
        vecs[17] = mk(1, 300, 468, 1, 1, 300, 470, 'h214, 63,   'h83F);
        vecs[18] = mk(1, 300, 468, 1, 1, 363, 531, 'h215, 992,  'hBE0);
        vecs[19] = mk(1, 300, 468, 1, 1, 364, 468, 'h216, 0,    'h216);
        vecs[20] = mk(1, 1330, 468, 1, 1, 1330, 468, 'h217, 31, 'h81F);
        vecs[21] = mk(1, 1330, 468, 1, 1, 1343, 468, 'h218, 25, 'h819);
        vecs[22] = mk(1, 1330, 468, 1, 1, 0,    468, 'h111, 0,  'h111);

        exp_l = '{0, 1, 1, 2, 2, 3, 3, 0};
        exp_p = '{1, 2, 1, 0, 1, 2, 1, 0};
        exp_o = '{1, 2, 2, 2, 2, 2, 2, 2};
        exp_d = '{0, 0, 1, 1, 1, 1, 1, 1};

        // Reset holds every output at zero even with a sprite pixel on the input.
        rst = 1'b1; en = 1'b1; start = 1'b0; mirror = 1'b0;
        xpos = 11'd300; ypos = 11'd468;
        vin.hcount = 11'd300; vin.vcount = 11'd468; vin.rgb = 12'hFFF;
        vin.vsync = 1'b0; vin.hsync = 1'b0; vin.vblnk = 1'b0; vin.hblnk = 1'b0;
        repeat (3) tick();
        check("reset out.rgb", int'(orgb_a), 0);
        check("reset out.hcount", int'(ohc_a), 0);
        check("reset pixel_addr", int'(addr_a), 0);
        check("reset frame_idx", int'(fi_l), 0);
        check("reset done", int'(done_o), 0);
        rst = 1'b0;

        // Pixel pipeline: address one cycle after the input pixel, rgb two cycles after.
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) begin
                drive_vec(vecs[i]);
            end else begin
                drive_vec(mk(0, 300, 468, 0, 1, 0, 0, 0, 0, 0));
            end
            tick();
            if (i < NV) begin
                check($sformatf("pixel_addr[%0d]", i), addr_of(vecs[i].sel), int'(vecs[i].addr));
            end
            if (i >= 1) begin
                check($sformatf("out.rgb[%0d]", i-1), rgb_of(vecs[i-1].sel), int'(vecs[i-1].rgb_out));
                check($sformatf("out.hcount[%0d]", i-1), hc_of(vecs[i-1].sel), int'(vecs[i-1].hc));
            end
        end

        // Animation: IDLE ignores steps, then start and a run of vsync edges.
        vsync_pulse(1'b0);
        check("idle frame loop", int'(fi_l), 0);
        check("idle frame pingpong", int'(fi_p), 0);
        start_pulse();
        check("start frame loop", int'(fi_l), 0);
        check("start frame oneshot", int'(fi_o), 0);
        for (int k = 0; k < 8; k++) begin
            vsync_pulse(1'b0);
            check($sformatf("loop frame edge %0d", k+1), int'(fi_l), exp_l[k]);
            check($sformatf("pingpong frame edge %0d", k+1), int'(fi_p), exp_p[k]);
            check($sformatf("oneshot frame edge %0d", k+1), int'(fi_o), exp_o[k]);
            check($sformatf("oneshot done edge %0d", k+1), int'(done_o), exp_d[k]);
        end
        check("loop done never set", int'(done_l), 0);
        start_pulse();
        check("restart oneshot frame", int'(fi_o), 0);
        check("restart oneshot done", int'(done_o), 0);

        // start coinciding with a vsync edge discards that tick.
        vsync_pulse(1'b0);
        vsync_pulse(1'b0);
        check("pre-collision loop frame", int'(fi_l), 1);
        check("pre-collision pingpong frame", int'(fi_p), 2);
        vsync_pulse(1'b1);
        check("collision loop frame", int'(fi_l), 0);
        check("collision pingpong frame", int'(fi_p), 0);
        vsync_pulse(1'b0);
        check("post-collision loop frame", int'(fi_l), 0);
        check("post-collision pingpong frame", int'(fi_p), 1);
        vsync_pulse(1'b0);
        check("post-collision loop step", int'(fi_l), 1);

        // Asynchronous reset in the middle of a clock period.
        drive_vec(mk(0, 300, 468, 0, 1, 301, 468, 'h456, 0, 0));
        tick();
        tick();
        check("pre-reset out.rgb", int'(orgb_a), 'h801);
        #2;
        rst = 1'b1;
        #1;
        check("async reset out.rgb", int'(orgb_a), 0);
        check("async reset out.hcount", int'(ohc_a), 0);
        check("async reset pixel_addr", int'(addr_a), 0);
        check("async reset frame_idx", int'(fi_l), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        check("post-reset out.rgb", int'(orgb_a), 'h801);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
